parking_ctrl: RTL and testbench

- Control FSM directly upstream of the speed/vehicle-count datapath.
- Converts two raw IR gate sensors (sen_a outer, sen_b inner) into the datapath command strobes: init, count, cal, up, down, en, dis.
- Consumes the datapath results num_veh, speed and done, and decides whether to open the barrier for entry or exit.
- Flags overspeed and lot-full events.

---
 rtl/parking_ctrl_if.sv | 30 +++
 rtl/parking_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_parking_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_ctrl_if.sv
// Signal bundle between the parking controller and its speed/vehicle-count datapath.
// Handshake: cal requests one division; speed is valid only while done=1; there is no backpressure.
interface parking_ctrl_if #(
    parameter int WIDTH_SPEED = 14
);
    logic                   sen_a;
    logic                   sen_b;
    logic [1:0]             num_veh;
    logic [WIDTH_SPEED-1:0] speed;
    logic                   done;
    logic                   init;
    logic                   count;
    logic                   cal;
    logic                   up;
    logic                   down;
    logic                   en;
    logic                   dis;
    logic                   overspeed;
    logic                   full;

    modport slave (
        input  sen_a, sen_b, num_veh, speed, done,
        output init, count, cal, up, down, en, dis, overspeed, full
    );

    modport master (
        output sen_a, sen_b, num_veh, speed, done,
        input  init, count, cal, up, down, en, dis, overspeed, full
    );
endinterface

// File: rtl/parking_ctrl.sv
// Parking gate controller: turns two IR gate sensors into datapath strobes,
// decides entry/exit from the measured speed and vehicle count, and drives the barrier.
module parking_ctrl #(
    parameter int WIDTH_SPEED     = 14,
    parameter int MAX_VEH         = 3,
    parameter int SPEED_LIMIT     = 20,
    parameter int CLK_PER_MS      = 50000,
    parameter int MEAS_TIMEOUT_MS = 2000,
    parameter int HOLD_MS         = 3000
) (
    input  logic           clk,
    input  logic           reset_n,
    parking_ctrl_if.slave  io_bus,
    output logic [2:0]     o_dbg_state
);
    localparam int MS_MAX = (MEAS_TIMEOUT_MS > HOLD_MS) ? MEAS_TIMEOUT_MS : HOLD_MS;
    localparam int MSW    = $clog2(MS_MAX + 1);
    localparam int PW     = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [PW-1:0]          LP_PRE_LAST    = PW'(CLK_PER_MS - 1);
    localparam logic [MSW-1:0]         LP_MEAS_TO     = MSW'(MEAS_TIMEOUT_MS);
    localparam logic [MSW-1:0]         LP_HOLD        = MSW'(HOLD_MS);
    localparam logic [1:0]             LP_MAX_VEH     = 2'(MAX_VEH);
    localparam logic [WIDTH_SPEED-1:0] LP_SPEED_LIMIT = WIDTH_SPEED'(SPEED_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MEAS = 3'd1,
        S_CALC = 3'd2,
        S_EXIT = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_sync_a;
    logic [2:0]       r_sync_b;
    logic [PW-1:0]    r_pre;
    logic [MSW-1:0]   r_ms;
    logic             w_tick;
    logic             w_ra, w_rb, w_la, w_lb;
    logic             w_cal, w_up, w_down, w_en, w_dis, w_full, w_ovs_set, w_ovs_clr;
    logic             r_init, r_count, r_cal, r_up, r_down, r_en, r_dis, r_full, r_ovs;

    // Bits [1:0] are the two synchronizer stages, bit [2] holds the previous level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[1:0], io_bus.sen_a};
            r_sync_b <= {r_sync_b[1:0], io_bus.sen_b};
        end
    end

    assign w_la = r_sync_a[1];
    assign w_lb = r_sync_b[1];
    assign w_ra = r_sync_a[1] & ~r_sync_a[2];
    assign w_rb = r_sync_b[1] & ~r_sync_b[2];

    assign w_tick = (r_pre == LP_PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Elapsed ms in the current state; restarts on each state change and saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ms <= '0;
        end else if (w_next != r_state) begin
            r_ms <= '0;
        end else if (w_tick && (r_ms != {MSW{1'b1}})) begin
            r_ms <= r_ms + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cal     = 1'b0;
        w_up      = 1'b0;
        w_down    = 1'b0;
        w_en      = 1'b0;
        w_dis     = 1'b0;
        w_full    = 1'b0;
        w_ovs_set = 1'b0;
        w_ovs_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ra && !w_rb) begin
                    if (io_bus.num_veh >= LP_MAX_VEH) begin
                        w_full = 1'b1;
                    end else begin
                        w_next = S_MEAS;
                    end
                end else if (w_rb && !w_ra && (io_bus.num_veh != 2'd0)) begin
                    w_en   = 1'b1;
                    w_next = S_EXIT;
                end
            end
            S_MEAS: begin
                if (w_rb) begin
                    w_cal  = 1'b1;
                    w_next = S_CALC;
                end else if (r_ms >= LP_MEAS_TO) begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (io_bus.done) begin
                    if (io_bus.speed <= LP_SPEED_LIMIT) begin
                        w_up      = 1'b1;
                        w_ovs_clr = 1'b1;
                        w_next    = S_HOLD;
                    end else begin
                        w_ovs_set = 1'b1;
                        w_next    = S_IDLE;
                    end
                end
            end
            S_EXIT: begin
                if (w_ra) begin
                    w_down = 1'b1;
                    w_next = S_HOLD;
                end else if (r_ms >= LP_MEAS_TO) begin
                    w_dis  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_HOLD: begin
                // Barrier stays open while anything is still in the gate.
                if ((r_ms >= LP_HOLD) && !w_la && !w_lb) begin
                    w_dis  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init  <= 1'b0;
            r_count <= 1'b0;
            r_cal   <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_en    <= 1'b0;
            r_dis   <= 1'b0;
            r_full  <= 1'b0;
            r_ovs   <= 1'b0;
        end else begin
            r_init  <= (w_next == S_IDLE);
            r_count <= (w_next == S_MEAS);
            r_cal   <= w_cal;
            r_up    <= w_up;
            r_down  <= w_down;
            r_en    <= w_en;
            r_dis   <= w_dis;
            r_full  <= w_full;
            if (w_ovs_set) begin
                r_ovs <= 1'b1;
            end else if (w_ovs_clr) begin
                r_ovs <= 1'b0;
            end
        end
    end

    assign io_bus.init      = r_init;
    assign io_bus.count     = r_count;
    assign io_bus.cal       = r_cal;
    assign io_bus.up        = r_up;
    assign io_bus.down      = r_down;
    assign io_bus.en        = r_en;
    assign io_bus.dis       = r_dis;
    assign io_bus.full      = r_full;
    assign io_bus.overspeed = r_ovs;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_parking_ctrl.sv
// Bench for parking_ctrl: directed sensor scenarios, a small datapath model,
// and an event scoreboard comparing every change of the output vector.
module tb_parking_ctrl;
    localparam int P       = 2;
    localparam int HOLD    = 3000;
    localparam int MEAS_TO = 2000;
    localparam int WS      = 14;
    localparam int EW      = 9 + 64;

    localparam logic [5:0] ST_NO   = 6'b000000;
    localparam logic [5:0] ST_CAL  = 6'b100000;
    localparam logic [5:0] ST_UP   = 6'b010000;
    localparam logic [5:0] ST_DOWN = 6'b001000;
    localparam logic [5:0] ST_EN   = 6'b000100;
    localparam logic [5:0] ST_DIS  = 6'b000010;
    localparam logic [5:0] ST_FULL = 6'b000001;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [2:0]    dbg_state;
    logic [8:0]    snap;
    logic [8:0]    prev_snap = '0;
    logic [WS-1:0] speed_cfg = '0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            mon_lo, mon_hi;
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    parking_ctrl_if #(.WIDTH_SPEED(WS)) bus ();

    parking_ctrl #(
        .WIDTH_SPEED(WS), .MAX_VEH(3), .SPEED_LIMIT(20), .CLK_PER_MS(P),
        .MEAS_TIMEOUT_MS(MEAS_TO), .HOLD_MS(HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .io_bus(bus), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign snap = {bus.init, bus.count, bus.cal, bus.up, bus.down,
                   bus.en, bus.dis, bus.full, bus.overspeed};

    // ---------------- datapath model: done 16 clk after cal ----------------
    always begin
        @(negedge clk);
        if (bus.cal) begin
            repeat (16) @(posedge clk);
            #1;
            bus.speed = speed_cfg;
            bus.done  = 1'b1;
            @(posedge clk);
            #1;
            bus.done  = 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (snap !== prev_snap) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d actual=%b required=no change", cyc, snap);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_lo = int'(mon_e[63:32]);
                mon_hi = int'(mon_e[31:0]);
                if (snap !== mon_e[72:64] || cyc < mon_lo || cyc > mon_hi) begin
                    n_fail++;
                    $display("FAIL event actual=%b@%0d required=%b@[%0d..%0d] (init,count,cal,up,down,en,dis,full,ovs)",
                             snap, cyc, mon_e[72:64], mon_lo, mon_hi);
                end
            end
        end
        prev_snap = snap;
    end

    // ---------------- helpers ----------------
    function automatic logic [8:0] mkw(logic i_v, logic c_v, logic [5:0] st, logic o_v);
        return {i_v, c_v, st, o_v};
    endfunction

    task automatic push(logic [8:0] wd, int lo, int hi);
        exp_q.push_back({wd, 32'(lo), 32'(hi)});
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
        end
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s pending_events actual=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        tick(20);
    endtask

    // sen_a, then sen_b gap_ms later; datapath answers with spd.
    task automatic do_entry(int gap_ms, int spd, logic ovs_in, logic ok);
        int d, d2, u;
        speed_cfg = WS'(spd);
        d = cyc;
        bus.sen_a = 1'b1;
        push(mkw(1'b0, 1'b1, ST_NO, ovs_in), d + 3, d + 3);
        tick(gap_ms * P);
        d2 = cyc;
        bus.sen_b = 1'b1;
        push(mkw(1'b0, 1'b0, ST_CAL, ovs_in), d2 + 3, d2 + 3);
        push(mkw(1'b0, 1'b0, ST_NO, ovs_in), d2 + 4, d2 + 4);
        u = d2 + 20;
        if (ok) begin
            push(mkw(1'b0, 1'b0, ST_UP, 1'b0), u, u);
            push(mkw(1'b0, 1'b0, ST_NO, 1'b0), u + 1, u + 1);
            push(mkw(1'b1, 1'b0, ST_DIS, 1'b0), u + HOLD * P - P, u + HOLD * P + 2);
            push(mkw(1'b1, 1'b0, ST_NO, 1'b0), u + HOLD * P - P + 1, u + HOLD * P + 3);
        end else begin
            push(mkw(1'b1, 1'b0, ST_NO, 1'b1), u, u);
        end
        tick(4);
        bus.sen_a = 1'b0;
        bus.sen_b = 1'b0;
        drain("entry", HOLD * P + 200);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d, d2, e, u, r;
        bus.sen_a   = 1'b0;
        bus.sen_b   = 1'b0;
        bus.num_veh = 2'd0;
        bus.speed   = '0;
        bus.done    = 1'b0;
        #2 reset_n = 1'b0;
        tick(3);
        chk("reset_state", int'(dbg_state), 0);
        chk("reset_outputs", int'(snap), 0);
        r = cyc;
        reset_n = 1'b1;
        push(mkw(1'b1, 1'b0, ST_NO, 1'b0), r + 1, r + 1);
        drain("release", 10);

        // 1: accepted entry
        do_entry(720, 20, 1'b0, 1'b1);
        chk("entry_back_idle", int'(dbg_state), 0);

        // 2: overspeed, then clearing entry
        do_entry(100, 144, 1'b0, 1'b0);
        chk("overspeed_sticky", int'(bus.overspeed), 1);
        chk("overspeed_idle", int'(dbg_state), 0);
        do_entry(100, 20, 1'b1, 1'b1);
        chk("overspeed_cleared", int'(bus.overspeed), 0);

        // 3: full lot
        bus.num_veh = 2'd3;
        d = cyc;
        bus.sen_a = 1'b1;
        push(mkw(1'b1, 1'b0, ST_FULL, 1'b0), d + 3, d + 3);
        push(mkw(1'b1, 1'b0, ST_NO, 1'b0), d + 4, d + 4);
        tick(3);
        bus.sen_a = 1'b0;
        drain("full", 20);
        chk("full_idle", int'(dbg_state), 0);

        // 4: exit, then ignored exit with empty lot
        bus.num_veh = 2'd2;
        d = cyc;
        bus.sen_b = 1'b1;
        push(mkw(1'b0, 1'b0, ST_EN, 1'b0), d + 3, d + 3);
        push(mkw(1'b0, 1'b0, ST_NO, 1'b0), d + 4, d + 4);
        tick(10);
        bus.sen_b = 1'b0;
        tick(500 * P - 10);
        d2 = cyc;
        bus.sen_a = 1'b1;
        e = d2 + 3;
        push(mkw(1'b0, 1'b0, ST_DOWN, 1'b0), e, e);
        push(mkw(1'b0, 1'b0, ST_NO, 1'b0), e + 1, e + 1);
        push(mkw(1'b1, 1'b0, ST_DIS, 1'b0), e + HOLD * P - P, e + HOLD * P + 2);
        push(mkw(1'b1, 1'b0, ST_NO, 1'b0), e + HOLD * P - P + 1, e + HOLD * P + 3);
        tick(4);
        bus.sen_a = 1'b0;
        drain("exit", HOLD * P + 200);
        bus.num_veh = 2'd0;
        bus.sen_b = 1'b1;
        tick(10);
        chk("exit_empty_ignored", int'(dbg_state), 0);
        bus.sen_b = 1'b0;
        drain("exit_empty", 5);

        // 5a: measurement timeout
        d = cyc;
        bus.sen_a = 1'b1;
        e = d + 3;
        push(mkw(1'b0, 1'b1, ST_NO, 1'b0), e, e);
        push(mkw(1'b1, 1'b0, ST_NO, 1'b0), e + MEAS_TO * P - P, e + MEAS_TO * P + 2);
        tick(3);
        bus.sen_a = 1'b0;
        drain("meas_timeout", MEAS_TO * P + 200);

        // 5b: exit timeout
        bus.num_veh = 2'd1;
        d = cyc;
        bus.sen_b = 1'b1;
        e = d + 3;
        push(mkw(1'b0, 1'b0, ST_EN, 1'b0), e, e);
        push(mkw(1'b0, 1'b0, ST_NO, 1'b0), e + 1, e + 1);
        push(mkw(1'b1, 1'b0, ST_DIS, 1'b0), e + MEAS_TO * P - P, e + MEAS_TO * P + 2);
        push(mkw(1'b1, 1'b0, ST_NO, 1'b0), e + MEAS_TO * P - P + 1, e + MEAS_TO * P + 3);
        tick(3);
        bus.sen_b = 1'b0;
        drain("exit_timeout", MEAS_TO * P + 200);

        // 5c: hold extended while sen_b stays occupied
        bus.num_veh = 2'd0;
        speed_cfg = WS'(5);
        d = cyc;
        bus.sen_a = 1'b1;
        push(mkw(1'b0, 1'b1, ST_NO, 1'b0), d + 3, d + 3);
        tick(50 * P);
        d2 = cyc;
        bus.sen_b = 1'b1;
        push(mkw(1'b0, 1'b0, ST_CAL, 1'b0), d2 + 3, d2 + 3);
        push(mkw(1'b0, 1'b0, ST_NO, 1'b0), d2 + 4, d2 + 4);
        u = d2 + 20;
        push(mkw(1'b0, 1'b0, ST_UP, 1'b0), u, u);
        push(mkw(1'b0, 1'b0, ST_NO, 1'b0), u + 1, u + 1);
        tick(4);
        bus.sen_a = 1'b0;
        tick(u + HOLD * P + 200 - cyc);
        chk("hold_stuck_open", int'(dbg_state), 4);
        d = cyc;
        bus.sen_b = 1'b0;
        push(mkw(1'b1, 1'b0, ST_DIS, 1'b0), d + 3, d + 3);
        push(mkw(1'b1, 1'b0, ST_NO, 1'b0), d + 4, d + 4);
        drain("hold_occupied", 50);

        // 6a: simultaneous edges ignored
        bus.num_veh = 2'd1;
        bus.sen_a = 1'b1;
        bus.sen_b = 1'b1;
        tick(10);
        chk("simultaneous_ignored", int'(dbg_state), 0);
        bus.sen_a = 1'b0;
        bus.sen_b = 1'b0;
        drain("simultaneous", 5);

        // 6b: reset in MEAS, then fresh entry
        bus.num_veh = 2'd0;
        d = cyc;
        bus.sen_a = 1'b1;
        push(mkw(1'b0, 1'b1, ST_NO, 1'b0), d + 3, d + 3);
        tick(100);
        chk("mid_meas_state", int'(dbg_state), 1);
        r = cyc;
        reset_n = 1'b0;
        push(mkw(1'b0, 1'b0, ST_NO, 1'b0), r, r);
        #1;
        chk("async_reset_outputs", int'(snap), 0);
        chk("async_reset_state", int'(dbg_state), 0);
        bus.sen_a = 1'b0;
        tick(5);
        r = cyc;
        reset_n = 1'b1;
        push(mkw(1'b1, 1'b0, ST_NO, 1'b0), r + 1, r + 1);
        drain("reset_release", 10);
        do_entry(100, 10, 1'b0, 1'b1);
        chk("final_idle", int'(dbg_state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
